// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory arbiter and its neighbours.
// NOP_WORD is also used by the decoder when it inserts bubbles.
package imem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_FETCH  = 2'd1,
    OWN_LOADER = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  localparam logic [31:0] NOP_WORD = 32'h00000013;
  localparam int          CNT_W    = 4;

endpackage

// File: rtl/imem_starve_ctr.sv
// Saturating count of consecutive cycles the fetch stage lost arbitration.
// Clear has priority over increment.
module imem_starve_ctr
  import imem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_limit
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_at_limit = (r_count >= LIMIT);

endmodule

// File: rtl/imem_arbiter.sv
// Arbiter/sequencer sharing a single-port instruction memory between fetch and loader.
// Grants are combinational; responses come back one cycle later, routed by a one-entry tag.
module imem_arbiter #(
  parameter int          DEPTH_BYTES  = 88,
  parameter int          STARVE_LIMIT = 4,
  parameter logic [31:0] NOP_WORD     = imem_pkg::NOP_WORD
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_f_req,
  input  logic [31:0] i_f_addr,
  output logic        o_f_gnt,
  output logic        o_f_rvalid,
  output logic [31:0] o_f_rdata,
  output logic        o_f_err,
  input  logic        i_l_req,
  input  logic        i_l_we,
  input  logic [31:0] i_l_addr,
  input  logic [31:0] i_l_wdata,
  input  logic        i_l_lock,
  output logic        o_l_gnt,
  output logic        o_l_rvalid,
  output logic [31:0] o_l_rdata,
  output logic        o_locked,
  output logic        o_m_en,
  output logic        o_m_we,
  output logic [31:0] o_m_addr,
  output logic [31:0] o_m_wdata,
  input  logic [31:0] i_m_rdata
);

  import imem_pkg::*;

  state_e r_state;
  state_e w_state_next;
  owner_e r_tag_owner;
  logic   r_tag_err;
  logic   r_tag_we;

  logic   w_f_gnt;
  logic   w_l_gnt;
  logic   w_f_err;
  logic   w_busy;
  logic   w_at_limit;
  logic   w_cnt_inc;
  logic   w_cnt_clr;

  // 33-bit compare so addresses near 2^32 cannot wrap into range.
  assign w_f_err = (i_f_addr[1:0] != 2'b00) ||
                   (({1'b0, i_f_addr} + 33'd3) >= 33'(DEPTH_BYTES));
  assign w_busy  = (r_tag_owner != OWN_NONE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:   if (i_l_lock) w_state_next = w_busy ? ST_DRAIN : ST_LOAD;
      ST_DRAIN: begin
        if (!i_l_lock)   w_state_next = ST_RUN;
        else if (!w_busy) w_state_next = ST_LOAD;
      end
      ST_LOAD:  if (!i_l_lock) w_state_next = ST_RUN;
      default:  w_state_next = ST_RUN;
    endcase
  end

  // A rising lock in RUN suppresses every grant so the drain is bounded to one response.
  always_comb begin
    w_f_gnt = 1'b0;
    w_l_gnt = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (!i_l_lock) begin
          if (i_f_req && (w_at_limit || !i_l_req)) w_f_gnt = 1'b1;
          else if (i_l_req)                        w_l_gnt = 1'b1;
        end
      end
      ST_LOAD: w_l_gnt = i_l_req;
      default: ;
    endcase
  end

  assign w_cnt_inc = (r_state == ST_RUN) && i_f_req && w_l_gnt;
  assign w_cnt_clr = w_f_gnt || !i_f_req ||
                     ((w_state_next == ST_LOAD) && (r_state != ST_LOAD));

  imem_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_inc     (w_cnt_inc),
    .i_clr     (w_cnt_clr),
    .o_at_limit(w_at_limit)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tag_owner <= OWN_NONE;
      r_tag_err   <= 1'b0;
      r_tag_we    <= 1'b0;
    end else begin
      r_tag_owner <= w_l_gnt ? OWN_LOADER : (w_f_gnt ? OWN_FETCH : OWN_NONE);
      r_tag_err   <= w_f_gnt & w_f_err;
      r_tag_we    <= w_l_gnt & i_l_we;
    end
  end

  assign o_f_gnt   = w_f_gnt;
  assign o_l_gnt   = w_l_gnt;
  assign o_locked  = (r_state == ST_LOAD);

  // Erroneous fetches are granted but never reach the array.
  assign o_m_en    = w_l_gnt | (w_f_gnt & ~w_f_err);
  assign o_m_we    = w_l_gnt & i_l_we;
  assign o_m_addr  = w_l_gnt ? i_l_addr : (w_f_gnt ? i_f_addr : 32'd0);
  assign o_m_wdata = w_l_gnt ? i_l_wdata : 32'd0;

  assign o_f_rvalid = (r_tag_owner == OWN_FETCH);
  assign o_f_err    = o_f_rvalid & r_tag_err;
  assign o_f_rdata  = !o_f_rvalid ? 32'd0 : (r_tag_err ? NOP_WORD : i_m_rdata);

  assign o_l_rvalid = (r_tag_owner == OWN_LOADER);
  assign o_l_rdata  = (o_l_rvalid && !r_tag_we) ? i_m_rdata : 32'd0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: tasks push expected responses at grant time,
// a negedge monitor pops and compares them when rvalid appears.
module tb_imem_arbiter;

  localparam int          WORDS = 22;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req, f_gnt, f_rvalid, f_err;
  logic [31:0] f_addr, f_rdata;
  logic        l_req, l_we, l_lock, l_gnt, l_rvalid;
  logic [31:0] l_addr, l_wdata, l_rdata;
  logic        locked, m_en, m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;

  logic [31:0] mem     [WORDS];
  logic [31:0] ref_mem [WORDS];
  logic [32:0] f_exp_q [$];
  logic [31:0] l_exp_q [$];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  imem_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_f_req(f_req), .i_f_addr(f_addr), .o_f_gnt(f_gnt), .o_f_rvalid(f_rvalid),
    .o_f_rdata(f_rdata), .o_f_err(f_err),
    .i_l_req(l_req), .i_l_we(l_we), .i_l_addr(l_addr), .i_l_wdata(l_wdata),
    .i_l_lock(l_lock), .o_l_gnt(l_gnt), .o_l_rvalid(l_rvalid), .o_l_rdata(l_rdata),
    .o_locked(locked), .o_m_en(m_en), .o_m_we(m_we), .o_m_addr(m_addr),
    .o_m_wdata(m_wdata), .i_m_rdata(m_rdata)
  );

  function automatic logic [31:0] init_word(input int k);
    return 32'h00000913 | (32'(k) << 20);
  endfunction

  // Single-port memory with one cycle of read latency.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < WORDS; k++) mem[k] <= init_word(k);
      m_rdata <= 32'd0;
    end else if (m_en && (m_addr < 32'(WORDS * 4))) begin
      if (m_we) mem[m_addr[6:2]] <= m_wdata;
      else      m_rdata <= mem[m_addr[6:2]];
    end
  end

  always @(negedge clk) begin
    if (rst_n && f_rvalid) begin
      n_checks++;
      if (f_exp_q.size() == 0) begin
        $display("FAIL f_resp_unexpected: got err=%0b data=%h, required no response", f_err, f_rdata);
      end else begin
        logic [32:0] e;
        e = f_exp_q.pop_front();
        if ({f_err, f_rdata} !== e)
          $display("FAIL f_resp: got err=%0b data=%h, required err=%0b data=%h", f_err, f_rdata, e[32], e[31:0]);
        else begin
          n_pass++;
          $display("fetch  resp err=%0b data=%h", f_err, f_rdata);
        end
      end
    end
    if (rst_n && l_rvalid) begin
      n_checks++;
      if (l_exp_q.size() == 0) begin
        $display("FAIL l_resp_unexpected: got data=%h, required no response", l_rdata);
      end else begin
        logic [31:0] e;
        e = l_exp_q.pop_front();
        if (l_rdata !== e)
          $display("FAIL l_resp: got data=%h, required %h", l_rdata, e);
        else begin
          n_pass++;
          $display("loader resp data=%h", l_rdata);
        end
      end
    end
  end

  task automatic set_idle();
    f_req = 0; f_addr = 0; l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0; l_lock = 0;
  endtask

  task automatic reinit_ref();
    for (int k = 0; k < WORDS; k++) ref_mem[k] = init_word(k);
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 0;
    reinit_ref();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_checks++;
    if ({f_gnt, f_rvalid, f_rdata, f_err, l_gnt, l_rvalid, l_rdata, locked, m_en, m_we, m_addr, m_wdata} !== '0)
      $display("FAIL reset_outputs: got f_rdata=%h l_rdata=%h locked=%0b m_en=%0b, required all 0", f_rdata, l_rdata, locked, m_en);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk); #1;
    n_checks++;
    if ({f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, locked, m_en} !== '0)
      $display("FAIL reset_release: got f_rvalid=%0b l_rvalid=%0b locked=%0b m_en=%0b, required all 0", f_rvalid, l_rvalid, locked, m_en);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_fetch_only();
    for (int i = 0; i < 3; i++) begin
      f_req = 1; f_addr = 32'(4 * i);
      @(negedge clk); #1;
      n_checks++;
      if ({f_gnt, l_gnt, m_en, m_we, m_addr} !== {4'b1010, f_addr})
        $display("FAIL fetch_gnt[%0d]: got f_gnt=%0b m_en=%0b m_addr=%h, required 1 1 %h", i, f_gnt, m_en, m_addr, f_addr);
      else n_pass++;
      f_exp_q.push_back({1'b0, ref_mem[i]});
      @(posedge clk); #1;
    end
    set_idle();
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if (f_exp_q.size() != 0) $display("FAIL fetch_drain: got %0d pending, required 0", f_exp_q.size());
    else n_pass++;
  endtask

  task automatic test_contention();
    int n_l = 0;
    f_req = 1; f_addr = 32'd16; l_req = 1; l_we = 0; l_addr = 32'd40;
    for (int c = 0; c < 10; c++) begin
      logic exp_f;
      exp_f = (c == 4) || (c == 9);
      @(negedge clk); #1;
      n_checks++;
      if ({f_gnt, l_gnt} !== {exp_f, ~exp_f} || m_addr !== (exp_f ? f_addr : l_addr))
        $display("FAIL contention[%0d]: got f_gnt=%0b l_gnt=%0b m_addr=%h, required f_gnt=%0b", c, f_gnt, l_gnt, m_addr, exp_f);
      else n_pass++;
      if (exp_f) begin
        f_exp_q.push_back({1'b0, ref_mem[f_addr[6:2]]});
        @(posedge clk); #1;
        f_addr = f_addr + 4;
      end else begin
        l_exp_q.push_back(ref_mem[l_addr[6:2]]);
        @(posedge clk); #1;
        n_l++;
        l_addr = 32'(40 + 4 * (n_l % 8));
      end
    end
    set_idle();
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if (f_exp_q.size() + l_exp_q.size() != 0) $display("FAIL contention_drain: got %0d pending, required 0", f_exp_q.size() + l_exp_q.size());
    else n_pass++;
  endtask

  task automatic test_errors();
    logic [31:0] addrs [5] = '{32'd2, 32'd88, 32'hFFFFFFFC, 32'd84, 32'd1};
    logic        errs  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      f_req = 1; f_addr = addrs[i];
      @(negedge clk); #1;
      n_checks++;
      if (f_gnt !== 1'b1 || m_en !== ~errs[i])
        $display("FAIL err_gnt[%h]: got f_gnt=%0b m_en=%0b, required 1 %0b", f_addr, f_gnt, m_en, ~errs[i]);
      else n_pass++;
      f_exp_q.push_back(errs[i] ? {1'b1, NOP} : {1'b0, ref_mem[f_addr[6:2]]});
      @(posedge clk); #1;
    end
    set_idle();
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_lock();
    f_req = 1; f_addr = 0;
    @(negedge clk); #1;
    n_checks++;
    if (f_gnt !== 1'b1) $display("FAIL lock_c0: got f_gnt=%0b, required 1", f_gnt); else n_pass++;
    f_exp_q.push_back({1'b0, ref_mem[0]});
    @(posedge clk); #1;
    f_addr = 32'd4; l_lock = 1;
    @(negedge clk); #1;
    n_checks++;
    if ({f_gnt, l_gnt, locked} !== 3'b000) $display("FAIL lock_c1: got f_gnt=%0b l_gnt=%0b locked=%0b, required 000", f_gnt, l_gnt, locked); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk); #1;
    n_checks++;
    if ({f_gnt, l_gnt, locked, m_en} !== 4'b0000) $display("FAIL lock_drain: got f_gnt=%0b locked=%0b m_en=%0b, required 000", f_gnt, locked, m_en); else n_pass++;
    @(posedge clk); #1;
    l_req = 1; l_we = 1; l_addr = 32'd4; l_wdata = 32'hDEADBEEF;
    @(negedge clk); #1;
    n_checks++;
    if ({locked, l_gnt, f_gnt, m_en, m_we} !== 5'b11011 || m_addr !== 32'd4 || m_wdata !== 32'hDEADBEEF)
      $display("FAIL lock_write: got locked=%0b l_gnt=%0b f_gnt=%0b m_we=%0b m_wdata=%h, required 1 1 0 1 deadbeef", locked, l_gnt, f_gnt, m_we, m_wdata);
    else n_pass++;
    l_exp_q.push_back(32'd0);
    ref_mem[1] = 32'hDEADBEEF;
    @(posedge clk); #1;
    l_we = 0; l_wdata = 0;
    @(negedge clk); #1;
    n_checks++;
    if ({l_gnt, f_gnt, m_we} !== 3'b100) $display("FAIL lock_read: got l_gnt=%0b f_gnt=%0b m_we=%0b, required 100", l_gnt, f_gnt, m_we); else n_pass++;
    l_exp_q.push_back(ref_mem[1]);
    @(posedge clk); #1;
    l_req = 0; l_lock = 0;
    @(negedge clk); #1;
    n_checks++;
    if ({locked, f_gnt} !== 2'b10) $display("FAIL lock_release: got locked=%0b f_gnt=%0b, required 10", locked, f_gnt); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk); #1;
    n_checks++;
    if ({locked, f_gnt} !== 2'b01) $display("FAIL lock_refetch: got locked=%0b f_gnt=%0b, required 01", locked, f_gnt); else n_pass++;
    f_exp_q.push_back({1'b0, ref_mem[1]});
    @(posedge clk); #1;
    set_idle();
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if (f_exp_q.size() + l_exp_q.size() != 0) $display("FAIL lock_pending: got %0d pending, required 0", f_exp_q.size() + l_exp_q.size());
    else n_pass++;
  endtask

  task automatic test_lock_vs_starve();
    f_req = 1; f_addr = 32'd8; l_req = 1; l_we = 0; l_addr = 32'd12;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      n_checks++;
      if ({f_gnt, l_gnt} !== 2'b01) $display("FAIL starve_build[%0d]: got f_gnt=%0b l_gnt=%0b, required 01", c, f_gnt, l_gnt); else n_pass++;
      l_exp_q.push_back(ref_mem[3]);
      @(posedge clk); #1;
    end
    l_lock = 1;
    @(negedge clk); #1;
    n_checks++;
    if ({f_gnt, l_gnt} !== 2'b00) $display("FAIL lock_precedence: got f_gnt=%0b l_gnt=%0b, required 00", f_gnt, l_gnt); else n_pass++;
    @(posedge clk); #1;
    l_lock = 0; l_req = 0;
    @(negedge clk); #1;
    n_checks++;
    if ({locked, f_gnt, l_gnt} !== 3'b000) $display("FAIL drain_unlock: got locked=%0b f_gnt=%0b, required 00", locked, f_gnt); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk); #1;
    n_checks++;
    if ({locked, f_gnt} !== 2'b01) $display("FAIL drain_to_run: got locked=%0b f_gnt=%0b, required 01", locked, f_gnt); else n_pass++;
    f_exp_q.push_back({1'b0, ref_mem[2]});
    @(posedge clk); #1;
    set_idle();
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    f_req = 1; f_addr = 32'd8;
    @(negedge clk); #1;
    n_checks++;
    if (f_gnt !== 1'b1) $display("FAIL rstmid_gnt: got f_gnt=%0b, required 1", f_gnt); else n_pass++;
    @(posedge clk); #1;
    set_idle();
    rst_n = 0;
    @(negedge clk); #1;
    n_checks++;
    if ({f_rvalid, l_rvalid, f_rdata, l_rdata, locked, m_en} !== '0)
      $display("FAIL rstmid_discard: got f_rvalid=%0b f_rdata=%h, required 0 0", f_rvalid, f_rdata);
    else n_pass++;
    f_exp_q.delete();
    l_exp_q.delete();
    reinit_ref();
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk); #1;
    n_checks++;
    if ({f_rvalid, l_rvalid, f_rdata, l_rdata, locked, f_gnt, l_gnt, m_en} !== '0)
      $display("FAIL rstmid_after: got f_rvalid=%0b locked=%0b, required 0 0", f_rvalid, locked);
    else n_pass++;
    @(posedge clk); #1;
    f_req = 1; f_addr = 32'd0;
    @(negedge clk); #1;
    n_checks++;
    if ({f_gnt, locked} !== 2'b10) $display("FAIL rstmid_run: got f_gnt=%0b locked=%0b, required 10", f_gnt, locked); else n_pass++;
    f_exp_q.push_back({1'b0, ref_mem[0]});
    @(posedge clk); #1;
    set_idle();
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if (f_exp_q.size() != 0) $display("FAIL rstmid_pending: got %0d pending, required 0", f_exp_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_contention();
    test_errors();
    test_lock();
    test_lock_vs_starve();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
